// File: rtl/soma_arb_if.sv
// Request/response bundle between NREQ section accumulators and the shared soma adder.
// master = requesters plus result consumer, slave = the arbiter.
interface soma_arb_if #(
   parameter int EXP  = 8,
   parameter int MAN  = 23,
   parameter int NREQ = 4
);
   localparam int W   = EXP + MAN + 1;
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_data;
   logic              busy;

   modport master (
      output req_valid,
      output req_a,
      output req_b,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid,
      input  rsp_id,
      input  rsp_data,
      input  busy
   );

   modport slave (
      input  req_valid,
      input  req_a,
      input  req_b,
      input  rsp_ready,
      output req_ready,
      output rsp_valid,
      output rsp_id,
      output rsp_data,
      output busy
   );
endinterface

// File: rtl/soma_arb.sv
// Round-robin scheduler sharing one soma FP adder (operand reg -> soma -> result reg).
// Define SOMA_ARB_PRIO_EN to give requester 0 fixed priority; rotation then covers 1..NREQ-1.
module soma_arb #(
   parameter int EXP  = 8,
   parameter int MAN  = 23,
   parameter int NREQ = 4
) (
   input  logic       clk,
   input  logic       rst,
   soma_arb_if.slave  io
);
   localparam int W   = EXP + MAN + 1;
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int SW  = MAN + 4;
   localparam int LZW = $clog2(SW + 1);
   localparam logic [EXP-1:0]        EMAX    = '1;
   localparam logic signed [EXP+1:0] EXP_TOP = (EXP+2)'((1 << EXP) - 1);
   localparam logic signed [EXP+1:0] EXP_ONE = (EXP+2)'(1);
   localparam logic [IDW-1:0]        LAST_ID = IDW'(NREQ - 1);
`ifdef SOMA_ARB_PRIO_EN
   localparam logic [IDW-1:0]        WRAP_ID = IDW'(1);
`else
   localparam logic [IDW-1:0]        WRAP_ID = '0;
`endif

   // Single-precision style add: hidden bit plus guard/round/sticky, round to nearest even.
   // Subnormals flush to zero, overflow saturates to infinity, exact cancellation gives +0.
   function automatic logic [W-1:0] soma_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic                  sx, sy;
      logic [EXP-1:0]        ex, ey, d;
      logic [MAN-1:0]        fx, fy;
      logic [SW-1:0]         xs, ys, ysh, lost, norm;
      logic [SW:0]           sum;
      logic [LZW-1:0]        lz;
      logic                  found, sticky, round_up, carry;
      logic [MAN:0]          rnd;
      logic signed [EXP+1:0] er;
      logic                  a_spec, b_spec, a_nan, b_nan;
      logic [W-1:0]          res;

      a_spec = (a[W-2:MAN] == EMAX);
      b_spec = (b[W-2:MAN] == EMAX);
      a_nan  = a_spec && (a[MAN-1:0] != '0);
      b_nan  = b_spec && (b[MAN-1:0] != '0);

      if (b[W-2:0] > a[W-2:0]) begin
         {sx, ex, fx} = b;
         {sy, ey, fy} = a;
      end else begin
         {sx, ex, fx} = a;
         {sy, ey, fy} = b;
      end

      xs   = (ex == '0) ? '0 : {1'b1, fx, 3'b000};
      ys   = (ey == '0) ? '0 : {1'b1, fy, 3'b000};
      d    = ex - ey;
      lost = '0;
      if (int'(d) >= SW) begin
         ysh    = '0;
         sticky = |ys;
      end else begin
         lost   = ~({SW{1'b1}} << d);
         ysh    = ys >> d;
         sticky = |(ys & lost);
      end
      ysh[0] = ysh[0] | sticky;

      if (sx ^ sy)
         sum = {1'b0, xs} - {1'b0, ysh};
      else
         sum = {1'b0, xs} + {1'b0, ysh};

      lz    = '0;
      found = 1'b0;
      for (int i = SW - 1; i >= 0; i--) begin
         if (!found) begin
            if (sum[i])
               found = 1'b1;
            else
               lz = lz + LZW'(1);
         end
      end

      er = $signed({2'b00, ex});
      if (sum[SW]) begin
         norm = sum[SW:1] | {{(SW-1){1'b0}}, sum[0]};
         er   = er + EXP_ONE;
      end else begin
         norm = sum[SW-1:0] << lz;
         er   = er - $signed((EXP+2)'(lz));
      end

      round_up     = norm[2] & (norm[1] | norm[0] | norm[3]);
      {carry, rnd} = {1'b0, norm[SW-1:3]} + (MAN+2)'(round_up);
      if (carry)
         er = er + EXP_ONE;

      if (!(carry | rnd[MAN]))
         res = '0;
      else if (er >= EXP_TOP)
         res = {sx, EMAX, {MAN{1'b0}}};
      else if (er < EXP_ONE)
         res = {sx, {(W-1){1'b0}}};
      else
         res = {sx, er[EXP-1:0], rnd[MAN-1:0]};

      if (a_nan || b_nan || (a_spec && b_spec && (a[W-1] != b[W-1])))
         res = {1'b0, EMAX, 1'b1, {(MAN-1){1'b0}}};
      else if (a_spec)
         res = a;
      else if (b_spec)
         res = b;
      return res;
   endfunction

   logic [W-1:0]   op_a [NREQ];
   logic [W-1:0]   op_b [NREQ];

   logic           a_v_reg, a_v_next;
   logic [IDW-1:0] a_id_reg, a_id_next;
   logic [W-1:0]   a_op1_reg, a_op1_next;
   logic [W-1:0]   a_op2_reg, a_op2_next;
   logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;
   logic           rsp_valid_reg, rsp_valid_next;
   logic [IDW-1:0] rsp_id_reg, rsp_id_next;
   logic [W-1:0]   rsp_data_reg, rsp_data_next;

   logic           out_free, a_free, take, ptr_adv;
   logic           grant_found;
   logic [IDW-1:0] grant_idx;
   logic [W-1:0]   soma_result;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_port
         assign op_a[gi]         = io.req_a[gi*W +: W];
         assign op_b[gi]         = io.req_b[gi*W +: W];
         assign io.req_ready[gi] = take && (grant_idx == IDW'(gi));
      end
   endgenerate

   // Rotating search starting at rr_ptr; in priority mode requester 0 overrides it.
   always_comb begin : grant_search
      int             j;
      logic [IDW-1:0] jj;
      j           = 0;
      jj          = '0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(rr_ptr_reg) + k;
         if (j >= NREQ)
            j = j - NREQ;
         jj = IDW'(j);
         if (!grant_found && io.req_valid[jj]) begin
            grant_found = 1'b1;
            grant_idx   = jj;
         end
      end
`ifdef SOMA_ARB_PRIO_EN
      if (io.req_valid[0]) begin
         grant_found = 1'b1;
         grant_idx   = '0;
      end
`endif
   end

   assign out_free    = !rsp_valid_reg || io.rsp_ready;
   assign a_free      = !a_v_reg || out_free;
   assign take        = rst && grant_found && a_free;
   assign soma_result = soma_add(a_op1_reg, a_op2_reg);
`ifdef SOMA_ARB_PRIO_EN
   assign ptr_adv     = take && (grant_idx != '0);
`else
   assign ptr_adv     = take;
`endif

   always_comb begin : next_state
      a_v_next       = a_v_reg;
      a_id_next      = a_id_reg;
      a_op1_next     = a_op1_reg;
      a_op2_next     = a_op2_reg;
      rr_ptr_next    = rr_ptr_reg;
      rsp_valid_next = rsp_valid_reg;
      rsp_id_next    = rsp_id_reg;
      rsp_data_next  = rsp_data_reg;

      if (take) begin
         a_v_next   = 1'b1;
         a_id_next  = grant_idx;
         a_op1_next = op_a[grant_idx];
         a_op2_next = op_b[grant_idx];
      end else if (out_free) begin
         a_v_next = 1'b0;
      end

      if (ptr_adv)
         rr_ptr_next = (grant_idx == LAST_ID) ? WRAP_ID : grant_idx + 1'b1;

      // A consumer taking the result while stage A is full refills the output with no bubble.
      if (a_v_reg && out_free) begin
         rsp_valid_next = 1'b1;
         rsp_id_next    = a_id_reg;
         rsp_data_next  = soma_result;
      end else if (io.rsp_ready) begin
         rsp_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_v_reg       <= 1'b0;
         a_id_reg      <= '0;
         a_op1_reg     <= '0;
         a_op2_reg     <= '0;
         rr_ptr_reg    <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= '0;
         rsp_data_reg  <= '0;
      end else begin
         a_v_reg       <= a_v_next;
         a_id_reg      <= a_id_next;
         a_op1_reg     <= a_op1_next;
         a_op2_reg     <= a_op2_next;
         rr_ptr_reg    <= rr_ptr_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_id_reg    <= rsp_id_next;
         rsp_data_reg  <= rsp_data_next;
      end
   end

   assign io.rsp_valid = rsp_valid_reg;
   assign io.rsp_id    = rsp_id_reg;
   assign io.rsp_data  = rsp_data_reg;
   assign io.busy      = a_v_reg | rsp_valid_reg;
endmodule

// File: tb/tb_soma_arb.sv
// Bench for soma_arb: operands are integer-valued floats so every sum is exact, and a
// queue-based model of the two-deep pipeline plus round-robin pointer predicts each cycle.
module tb_soma_arb;
   localparam int NREQ = 4;

   typedef struct {
      int          id;
      logic [31:0] data;
      int          age;
   } item_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   soma_arb_if #(.EXP(8), .MAN(23), .NREQ(NREQ)) bus ();

   soma_arb #(.EXP(8), .MAN(23), .NREQ(NREQ)) dut (
      .clk (clk),
      .rst (rst),
      .io  (bus)
   );

   int          checks   = 0;
   int          failures = 0;
   int          op_a_int [NREQ];
   int          op_b_int [NREQ];
   item_t       pipe_q [$];
   int          rr_model = 0;
   int          model_accepts = 0;
   int          dut_rsps = 0;
   logic [3:0]  obs_ready;
   logic        obs_rsp_valid, obs_busy;
   logic [1:0]  obs_id;
   logic [31:0] obs_data;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] int_to_fp(input int v);
      logic [31:0] r;
      int          m, p;
      if (v == 0) return 32'h0;
      m = (v < 0) ? -v : v;
      p = 0;
      for (int i = 0; i < 31; i++)
         if (((m >> i) & 1) != 0) p = i;
      r[31]    = (v < 0);
      r[30:23] = 8'(127 + p);
      r[22:0]  = 23'((m << (23 - p)) & 32'h7FFFFF);
      return r;
   endfunction

   function automatic int model_grant(input logic [3:0] v);
`ifdef SOMA_ARB_PRIO_EN
      if (v[0]) return 0;
`endif
      for (int k = 0; k < NREQ; k++) begin
         int j = (rr_model + k) % NREQ;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   function automatic int rand_op();
      return int'($urandom_range(0, 2097152)) - 1048576;
   endfunction

   // One clock cycle: drive after the falling edge, check, then advance the model.
   task automatic step(input logic rstv, input logic [3:0] v, input logic rr);
      int         g;
      logic [3:0] exp_ready;
      logic       exp_rv;
      item_t      it;
      @(negedge clk);
      rst           = rstv;
      bus.req_valid = v;
      bus.rsp_ready = rr;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[i*32 +: 32] = int_to_fp(op_a_int[i]);
         bus.req_b[i*32 +: 32] = int_to_fp(op_b_int[i]);
      end
      #1;
      obs_ready     = bus.req_ready;
      obs_rsp_valid = bus.rsp_valid;
      obs_busy      = bus.busy;
      obs_id        = bus.rsp_id;
      obs_data      = bus.rsp_data;

      g         = model_grant(v);
      exp_ready = 4'b0000;
      if (rstv && g >= 0 && (pipe_q.size() < 2 || rr))
         exp_ready = 4'(1 << g);
      exp_rv = (pipe_q.size() > 0) && (pipe_q[0].age >= 1);

      check_eq("req_ready", 64'(obs_ready), 64'(exp_ready));
      check_eq("rsp_valid", 64'(obs_rsp_valid), 64'(exp_rv));
      check_eq("busy", 64'(obs_busy), 64'(pipe_q.size() > 0));
      if (exp_rv) begin
         check_eq("rsp_id", 64'(obs_id), 64'(pipe_q[0].id));
         check_eq("rsp_data", 64'(obs_data), 64'(pipe_q[0].data));
      end
      if (rstv && obs_rsp_valid && rr) dut_rsps++;

      if (!rstv) begin
         pipe_q.delete();
         rr_model = 0;
      end else begin
         if (exp_rv && rr) begin
            $display("rsp   id=%0d data=%08h", pipe_q[0].id, pipe_q[0].data);
            void'(pipe_q.pop_front());
         end
         foreach (pipe_q[i]) pipe_q[i].age++;
         if (exp_ready != 4'b0000) begin
            it.id   = g;
            it.data = int_to_fp(op_a_int[g] + op_b_int[g]);
            it.age  = 0;
            pipe_q.push_back(it);
            model_accepts++;
            $display("grant id=%0d a=%0d b=%0d", g, op_a_int[g], op_b_int[g]);
`ifdef SOMA_ARB_PRIO_EN
            if (g != 0) rr_model = (g == NREQ - 1) ? 1 : g + 1;
`else
            rr_model = (g + 1) % NREQ;
`endif
         end
      end
   endtask

   initial begin
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      for (int i = 0; i < NREQ; i++) begin
         op_a_int[i] = rand_op();
         op_b_int[i] = rand_op();
      end

      step(1'b0, 4'b0000, 1'b1);
      step(1'b0, 4'b0000, 1'b1);
      check_eq("reset_rsp_valid", 64'(obs_rsp_valid), 64'd0);
      check_eq("reset_busy", 64'(obs_busy), 64'd0);
      check_eq("reset_rsp_id", 64'(obs_id), 64'd0);
      check_eq("reset_rsp_data", 64'(obs_data), 64'd0);

      // single op 1.0 + 2.0 from requester 2
      op_a_int[2] = 1;
      op_b_int[2] = 2;
      step(1'b1, 4'b0100, 1'b1);
      check_eq("t1_ready", 64'(obs_ready), 64'h4);
      step(1'b1, 4'b0000, 1'b1);
      check_eq("t1_busy_inflight", 64'(obs_busy), 64'd1);
      step(1'b1, 4'b0000, 1'b1);
      check_eq("t1_rsp_valid", 64'(obs_rsp_valid), 64'd1);
      check_eq("t1_rsp_id", 64'(obs_id), 64'd2);
      check_eq("t1_rsp_data", 64'(obs_data), 64'h40400000);
      step(1'b1, 4'b0000, 1'b1);
      check_eq("t1_busy_done", 64'(obs_busy), 64'd0);

      // all four valid, consumer always ready
      step(1'b0, 4'b0000, 1'b1);
      for (int k = 0; k < 8; k++) begin
         logic [3:0] want;
`ifdef SOMA_ARB_PRIO_EN
         want = 4'b0001;
`else
         want = 4'(1 << (k % NREQ));
`endif
         step(1'b1, 4'b1111, 1'b1);
         check_eq("t2_grant", 64'(obs_ready), 64'(want));
      end
      step(1'b1, 4'b0000, 1'b1);
      step(1'b1, 4'b0000, 1'b1);

      // backpressure: two accepted, then full stall
      dut_rsps      = 0;
      model_accepts = 0;
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 4'b1111, 1'b0);
         check_eq("t3_accept", 64'(obs_ready != 4'b0000), 64'(k < 2));
      end
      for (int k = 0; k < 4; k++) step(1'b1, 4'b0000, 1'b1);
      check_eq("t3_count", 64'(dut_rsps), 64'(model_accepts));
      check_eq("t3_idle", 64'(obs_busy), 64'd0);

      // reset with both stages occupied
      step(1'b1, 4'b1111, 1'b0);
      step(1'b1, 4'b1111, 1'b0);
      step(1'b0, 4'b1111, 1'b0);
      step(1'b1, 4'b1110, 1'b1);
      check_eq("t4_rsp_valid", 64'(obs_rsp_valid), 64'd0);
      check_eq("t4_busy", 64'(obs_busy), 64'd0);
      check_eq("t4_grant", 64'(obs_ready), 64'h2);

      // pointer wrap 3 -> 0 -> 1
      step(1'b0, 4'b0000, 1'b1);
      step(1'b1, 4'b1000, 1'b1);
      check_eq("t5_grant3", 64'(obs_ready), 64'h8);
      step(1'b1, 4'b0001, 1'b1);
      check_eq("t5_grant0", 64'(obs_ready), 64'h1);
      step(1'b1, 4'b1110, 1'b1);
      check_eq("t5_grant1", 64'(obs_ready), 64'h2);

`ifdef SOMA_ARB_PRIO_EN
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 4'b0011, 1'b1);
         check_eq("t6_prio0", 64'(obs_ready), 64'h1);
      end
      step(1'b1, 4'b0010, 1'b1);
      check_eq("t6_grant1", 64'(obs_ready), 64'h2);
`endif

      // randomized traffic with occasional reset and cancelling operands
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            op_a_int[i] = rand_op();
            op_b_int[i] = ($urandom_range(0, 7) == 0) ? -op_a_int[i] : rand_op();
         end
         step(($urandom_range(0, 99) != 0), 4'($urandom), ($urandom_range(0, 3) != 0));
      end
      for (int n = 0; n < 4; n++) step(1'b1, 4'b0000, 1'b1);
      check_eq("final_idle", 64'(obs_busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
